// File: rtl/result_uart_tx.sv
// Captures the Reduceron result/state/heap on a rising finish and sends them as one
// ASCII hex line ("RRRRR SS HHHH\r\n") over an 8N1 UART transmitter.
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [17:0] result,
    input  logic [6:0]  state,
    input  logic [14:0] heap,
    input  logic        finish,
    output logic        txd,
    output logic        busy,
    output logic        done
);
    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]        fsm_q, fsm_d;
    logic              armed_q, armed_d;
    logic [17:0]       cap_result_q, cap_result_d;
    logic [6:0]        cap_state_q, cap_state_d;
    logic [14:0]       cap_heap_q, cap_heap_d;
    logic [3:0]        char_idx_q, char_idx_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [7:0]        cur_byte;
    logic [2:0]        bit_nxt;
    logic              bit_end;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'b0000, n}) : (8'h37 + {4'b0000, n});
    endfunction

    // Character currently being framed, selected from the frozen capture registers.
    always_comb begin
        cur_byte = 8'h0A;
        case (char_idx_q)
            4'd0:    cur_byte = hex_ascii({2'b00, cap_result_q[17:16]});
            4'd1:    cur_byte = hex_ascii(cap_result_q[15:12]);
            4'd2:    cur_byte = hex_ascii(cap_result_q[11:8]);
            4'd3:    cur_byte = hex_ascii(cap_result_q[7:4]);
            4'd4:    cur_byte = hex_ascii(cap_result_q[3:0]);
            4'd5:    cur_byte = 8'h20;
            4'd6:    cur_byte = hex_ascii({1'b0, cap_state_q[6:4]});
            4'd7:    cur_byte = hex_ascii(cap_state_q[3:0]);
            4'd8:    cur_byte = 8'h20;
            4'd9:    cur_byte = hex_ascii({1'b0, cap_heap_q[14:12]});
            4'd10:   cur_byte = hex_ascii(cap_heap_q[11:8]);
            4'd11:   cur_byte = hex_ascii(cap_heap_q[7:4]);
            4'd12:   cur_byte = hex_ascii(cap_heap_q[3:0]);
            4'd13:   cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    assign bit_nxt = bit_idx_q + 3'd1;
    assign bit_end = (baud_q == BAUD_LAST);

    // txd is registered, so each transition loads the level of the bit being entered.
    always_comb begin
        fsm_d        = fsm_q;
        armed_d      = armed_q;
        cap_result_d = cap_result_q;
        cap_state_d  = cap_state_q;
        cap_heap_d   = cap_heap_q;
        char_idx_d   = char_idx_q;
        bit_idx_d    = bit_idx_q;
        baud_d       = baud_q;
        txd_d        = txd_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (!finish) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    cap_result_d = result;
                    cap_state_d  = state;
                    cap_heap_d   = heap;
                    armed_d      = 1'b0;
                    busy_d       = 1'b1;
                    txd_d        = 1'b0;
                    char_idx_d   = 4'd0;
                    bit_idx_d    = 3'd0;
                    baud_d       = '0;
                    fsm_d        = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    txd_d     = cur_byte[0];
                    fsm_d     = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        txd_d = 1'b1;
                        fsm_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_nxt;
                        txd_d     = cur_byte[bit_nxt];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (char_idx_q == 4'd14) begin
                        char_idx_d = 4'd0;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        fsm_d      = S_IDLE;
                    end else begin
                        char_idx_d = char_idx_q + 4'd1;
                        txd_d      = 1'b0;
                        fsm_d      = S_START;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q        <= S_IDLE;
            armed_q      <= 1'b1;
            cap_result_q <= '0;
            cap_state_q  <= '0;
            cap_heap_q   <= '0;
            char_idx_q   <= '0;
            bit_idx_q    <= '0;
            baud_q       <= '0;
            txd_q        <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            armed_q      <= armed_d;
            cap_result_q <= cap_result_d;
            cap_state_q  <= cap_state_d;
            cap_heap_q   <= cap_heap_d;
            char_idx_q   <= char_idx_d;
            bit_idx_q    <= bit_idx_d;
            baud_q       <= baud_d;
            txd_q        <= txd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: a UART line decoder pops expected bytes from a scoreboard
// queue filled whenever a message-starting finish edge is driven.
module tb_result_uart_tx;
    localparam int CPB = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [17:0] result = '0;
    logic [6:0]  state = '0;
    logic [14:0] heap = '0;
    logic        finish = 1'b0;
    logic        txd, busy, done;

    int checks = 0;
    int errors = 0;
    int rx_count = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [17:0] r;
        logic [6:0]  s;
        logic [14:0] h;
        string       exp;
    } vec_t;
    vec_t tbl[4];

    always #5 clock = ~clock;

    result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clock  (clock),
        .reset  (reset),
        .result (result),
        .state  (state),
        .heap   (heap),
        .finish (finish),
        .txd    (txd),
        .busy   (busy),
        .done   (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Independent text model: zero-extend each field to whole nibbles, print uppercase hex.
    function automatic string model(input logic [17:0] r, input logic [6:0] s, input logic [14:0] h);
        string hx;
        string m;
        logic [19:0] rr;
        logic [7:0]  ss;
        logic [15:0] hh;
        int n;
        hx = "0123456789ABCDEF";
        m  = "";
        rr = {2'b00, r};
        ss = {1'b0, s};
        hh = {1'b0, h};
        for (int i = 4; i >= 0; i--) begin
            n = int'(rr[i*4 +: 4]);
            m = {m, hx.substr(n, n)};
        end
        m = {m, " "};
        for (int i = 1; i >= 0; i--) begin
            n = int'(ss[i*4 +: 4]);
            m = {m, hx.substr(n, n)};
        end
        m = {m, " "};
        for (int i = 3; i >= 0; i--) begin
            n = int'(hh[i*4 +: 4]);
            m = {m, hx.substr(n, n)};
        end
        return m;
    endfunction

    task automatic push_exp(input string e);
        for (int i = 0; i < e.len(); i++) sb.push_back(e.getc(i));
        sb.push_back(8'h0D);
        sb.push_back(8'h0A);
    endtask

    // Line decoder: samples each bit in its middle; bytes overlapping a reset are dropped.
    logic [9:0] mon_bits;
    bit         mon_abort;
    logic [7:0] mon_exp;
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && txd === 1'b0) begin
                mon_abort = 1'b0;
                mon_bits  = '0;
                mon_bits[0] = 1'b0;
                for (int c = 1; c <= 9*CPB + CPB/2; c++) begin
                    @(negedge clock);
                    if (reset) mon_abort = 1'b1;
                    if (c % CPB == CPB/2) mon_bits[c/CPB] = txd;
                end
                if (!mon_abort) begin
                    chk("start_bit", {31'b0, mon_bits[0]}, 32'd0);
                    chk("stop_bit", {31'b0, mon_bits[9]}, 32'd1);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %02h required none", mon_bits[8:1]);
                    end else begin
                        mon_exp = sb.pop_front();
                        chk("rx_byte", {24'b0, mon_bits[8:1]}, {24'b0, mon_exp});
                    end
                    rx_count++;
                end
            end
        end
    end

    // Sends one message and checks start latency, busy length, done pulse and byte delivery.
    task automatic run_msg(input logic [17:0] r, input logic [6:0] s, input logic [14:0] h,
                           input string exp, input int glitch, input bit chg);
        int cnt;
        bit seen;
        @(negedge clock);
        result = r;
        state  = s;
        heap   = h;
        finish = 1'b1;
        push_exp(exp);
        @(negedge clock);
        chk("start_latency_txd", {31'b0, txd}, 32'd0);
        chk("busy_rise", {31'b0, busy}, 32'd1);
        chk("done_low_at_start", {31'b0, done}, 32'd0);
        cnt  = 1;
        seen = 1'b0;
        for (int i = 0; i < 700 && !seen; i++) begin
            if (chg && cnt == 1) result = 18'h00001;
            if (cnt == glitch) finish = 1'b0;
            if (cnt == glitch + 1) finish = 1'b1;
            @(negedge clock);
            if (done) seen = 1'b1;
            else if (busy) cnt++;
        end
        chk("done_seen", {31'b0, seen}, 32'd1);
        chk("busy_cycles", cnt, 150 * CPB);
        chk("busy_fall_with_done", {31'b0, busy}, 32'd0);
        chk("txd_idle_at_done", {31'b0, txd}, 32'd1);
        chk("queue_drained", sb.size(), 32'd0);
        @(negedge clock);
        chk("done_one_cycle", {31'b0, done}, 32'd0);
    endtask

    initial begin
        int bad;
        int rx_before;
        tbl[0] = '{18'h2A5F3, 7'h41, 15'h7FFF, "2A5F3 41 7FFF"};
        tbl[1] = '{18'h00000, 7'h00, 15'h0000, "00000 00 0000"};
        tbl[2] = '{18'h3FFFF, 7'h7F, 15'h7FFF, "3FFFF 7F 7FFF"};
        tbl[3] = '{18'h1C9E0, 7'h5B, 15'h30AD, "1C9E0 5B 30AD"};

        // Reset idle
        reset  = 1'b1;
        finish = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("rst_txd", {31'b0, txd}, 32'd1);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_done", {31'b0, done}, 32'd0);
        end
        reset = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(negedge clock);
            if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 32'd0);

        // Table-driven messages
        for (int i = 0; i < 4; i++) begin
            run_msg(tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].exp, -1, 1'b0);
            @(negedge clock);
            finish = 1'b0;
            @(negedge clock);
        end

        // Capture freeze with finish held high
        run_msg(18'h1B0C7, 7'h3E, 15'h4D21, model(18'h1B0C7, 7'h3E, 15'h4D21), -1, 1'b1);
        rx_before = rx_count;
        bad = 0;
        repeat (1400) begin
            @(negedge clock);
            if (busy !== 1'b0) bad++;
        end
        chk("level_finish_single_msg", bad, 32'd0);
        chk("level_finish_no_bytes", rx_count - rx_before, 32'd0);
        @(negedge clock);
        finish = 1'b0;
        run_msg(18'h00001, 7'h3E, 15'h4D21, model(18'h00001, 7'h3E, 15'h4D21), -1, 1'b0);

        // Finish edge during character 7 is ignored
        @(negedge clock);
        finish = 1'b0;
        @(negedge clock);
        run_msg(18'h2F00D, 7'h12, 15'h6B4E, model(18'h2F00D, 7'h12, 15'h6B4E), 290, 1'b0);
        rx_before = rx_count;
        bad = 0;
        repeat (700) begin
            @(negedge clock);
            if (busy !== 1'b0) bad++;
        end
        chk("busy_edge_not_queued", bad, 32'd0);
        chk("busy_edge_no_bytes", rx_count - rx_before, 32'd0);
        @(negedge clock);
        finish = 1'b0;
        @(negedge clock);

        // Reset during data bits of character 3
        @(negedge clock);
        result = 18'h0ABCD;
        state  = 7'h6A;
        heap   = 15'h1234;
        finish = 1'b1;
        push_exp(model(18'h0ABCD, 7'h6A, 15'h1234));
        repeat (131) @(negedge clock);
        chk("busy_before_abort", {31'b0, busy}, 32'd1);
        reset  = 1'b1;
        finish = 1'b0;
        @(negedge clock);
        chk("abort_txd", {31'b0, txd}, 32'd1);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        sb.delete();
        bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0 || txd !== 1'b1) bad++;
        end
        chk("abort_quiet", bad, 32'd0);
        run_msg(18'h35A5A, 7'h09, 15'h5F0F, model(18'h35A5A, 7'h09, 15'h5F0F), -1, 1'b0);
        @(negedge clock);
        finish = 1'b0;
        repeat (5) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
